toggle_event_rx: RTL
====================

// Module: toggle_event_rx
// PURPOSE
//  Receive end of the toggle-event link: the sender's T flip-flop flips a
//  single line once per event. This block synchronises that line into clk,
//  turns each transition back into a one-cycle pulse and queues events in a
//  saturating counter. A consumer drains events with valid/ready, and each
//  consumed event flips ack_t back to the sender.
// PARAMETERS
//  SYNC_STAGES  2  synchroniser depth on t_in (legal >= 2)
//  CNT_W        4  width of pending-event counter (max 2**CNT_W-1 events)
// PORTS
//  clk       in   1      rising-edge clock, only clock
//  rst       in   1      synchronous, active-high reset
//  t_in      in   1      toggle-encoded event line, asynchronous to clk
//  ev_pulse  out  1      one-cycle pulse per detected t_in transition
//  ev_valid  out  1      high while pending != 0
//  ev_ready  in   1      consumer pops one event when ev_valid && ev_ready
//  pending   out  CNT_W  number of queued, unconsumed events
//  overflow  out  1      sticky: an event was dropped at saturation
//  clr_ovf   in   1      clears overflow
//  ack_t     out  1      toggles once per popped event
// BEHAVIOUR
//  - Reset, sampled on posedge clk when rst=1: sync chain, prev, ev_pulse,
//    pending, overflow, ack_t all <= 0. rst overrides every other input.
//  - Link contract: sender resets its toggle line to 0. If t_in=1 when rst
//    deasserts, one event is detected; this is the defined behaviour.
//  - Sync: sync[0] <= t_in; sync[i] <= sync[i-1]; prev <= sync[last].
//  - detect = sync[last] ^ prev (combinational). ev_pulse <= detect.
//  - Latency: t_in change settled before edge E0 -> ev_pulse high for exactly
//    one cycle after edge E0+SYNC_STAGES (3rd edge for default). pending
//    updates on the same edge as ev_pulse rises.
//  - Each t_in transition = one event. Transitions closer than SYNC_STAGES+1
//    cycles apart are not guaranteed; a sub-cycle glitch may be lost.
//  - pop = ev_valid && ev_ready. ev_valid = (pending != 0), from registers.
//  - pending update per edge:
//      detect & !pop -> +1, unless pending==MAX: hold, overflow <= 1
//      !detect & pop -> -1
//      detect & pop  -> unchanged (no overflow, even at MAX)
//      neither       -> unchanged
//    MAX = 2**CNT_W-1; never wraps. pending==0 with ev_ready=1: no pop.
//  - ack_t <= ~ack_t on every pop edge; otherwise holds.
//  - overflow: set on dropped event; cleared by clr_ovf. If set and clr_ovf
//    occur in the same cycle, set wins (overflow stays 1).
//  - Reset mid-operation: queued events and in-flight toggles discarded;
//    outputs 0 from the first edge with rst=1.
// TESTING (SYNC_STAGES=2 unless stated)
//  1 rst 2 cycles, t_in=0 -> all outputs 0; idle 10 cycles -> no ev_pulse.
//  2 t_in 0->1 before edge E0, ev_ready=0 -> ev_pulse only in cycle after
//    E0+2, pending=1, ev_valid=1; ev_ready=1 1 cycle -> pending=0, ack_t=1.
//  3 5 toggles 4 cycles apart, ev_ready=0 -> pending=5; then ev_ready=1 ->
//    pops on 5 consecutive edges, pending=0, ack_t toggled 5x (ends 1).
//  4 CNT_W=2: 4 toggles, no pops -> pending=3, overflow=1 after 4th;
//    clr_ovf 1 cycle -> overflow=0, pending=3.
//  5 CNT_W=2, pending=3, ev_ready=1 on the detect edge -> pending stays 3,
//    overflow stays 0, ack_t toggles.
//  6 pending=2 while draining, rst=1 one cycle -> after that edge pending=0,
//    ev_valid=0, overflow=0, ack_t=0, ev_pulse=0.

Source files
------------

// File: rtl/toggle_event_rx.sv
// Receive side of the toggle-event link: synchronises the toggle line, turns
// each transition into a pulse, queues events and hands them out via valid/ready.
module toggle_event_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             t_in_i,
  output logic             ev_pulse_o,
  output logic             ev_valid_o,
  input  logic             ev_ready_i,
  output logic [CNT_W-1:0] pending_o,
  output logic             overflow_o,
  input  logic             clr_ovf_i,
  output logic             ack_t_o
);

  localparam logic [CNT_W-1:0] PendMax = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   pulse_q, pulse_d;
  logic [CNT_W-1:0]       pending_q, pending_d;
  logic                   ovf_q, ovf_d;
  logic                   ack_q, ack_d;
  logic                   detect;
  logic                   pop;

  assign detect     = sync_q[SYNC_STAGES-1] ^ prev_q;
  assign ev_valid_o = (pending_q != '0);
  assign pop        = ev_valid_o && ev_ready_i;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], t_in_i};
    prev_d    = sync_q[SYNC_STAGES-1];
    pulse_d   = detect;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    ack_d     = ack_q;

    if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end

    // A simultaneous detect and pop cancel out, so nothing is dropped even at MAX.
    if (detect && !pop) begin
      if (pending_q == PendMax) begin
        ovf_d = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end else if (!detect && pop) begin
      pending_d = pending_q - 1'b1;
    end

    if (pop) begin
      ack_d = ~ack_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      pulse_q   <= 1'b0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      ack_q     <= ack_d;
    end
  end

  assign ev_pulse_o = pulse_q;
  assign pending_o  = pending_q;
  assign overflow_o = ovf_q;
  assign ack_t_o    = ack_q;

endmodule
